// File: rtl/gf_pow_engine.sv
// gf_pow_engine: per-lane GF(2^8) x^E by LSB-first square-and-multiply, one exponent bit per cycle.
// Latency 9 cycles accept->out_valid; with GF_POW_EARLY_EXIT_EN it stops once no exponent bits remain.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module gf_pow_engine #(
    parameter int         LANES = 4,
    parameter logic [7:0] POLY  = 8'h1B
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_exp,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] base_q  [LANES];
    logic [7:0] acc_q   [LANES];
    logic [7:0] base_sq [LANES];
    logic [7:0] acc_nx  [LANES];
    logic [7:0] exp_q;
    logic [3:0] cnt_q;
    logic       accept;
    logic       step;

    // MSB-first shift-and-add, reducing after every shift so no bit escapes the lane.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            p = {p[6:0], 1'b0} ^ (p[7] ? POLY : 8'h00);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            base_sq[i] = gf_mul(base_q[i], base_q[i]);
            acc_nx[i]  = exp_q[0] ? gf_mul(acc_q[i], base_q[i]) : acc_q[i];
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
`ifdef GF_POW_EARLY_EXIT_EN
                    state_nx = (in_exp == 8'h00) ? DONE : RUN;
`else
                    state_nx = RUN;
`endif
                end
            end
            RUN: begin
                step = 1'b1;
`ifdef GF_POW_EARLY_EXIT_EN
                if ((exp_q[7:1] == 7'd0) || (cnt_q == 4'd7)) state_nx = DONE;
`else
                if (cnt_q == 4'd7) state_nx = DONE;
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        out_data = '0;
        if (state == DONE) begin
            for (int i = 0; i < LANES; i++) out_data[8*i +: 8] = acc_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            exp_q <= 8'h00;
            cnt_q <= 4'd0;
            for (int i = 0; i < LANES; i++) begin
                base_q[i] <= 8'h00;
                acc_q[i]  <= 8'h00;
            end
        end else begin
            state <= state_nx;
            if (accept) begin
                exp_q <= in_exp;
                cnt_q <= 4'd0;
                for (int i = 0; i < LANES; i++) begin
                    base_q[i] <= in_data[8*i +: 8];
                    acc_q[i]  <= 8'h01;
                end
            end else if (step) begin
                exp_q <= {1'b0, exp_q[7:1]};
                cnt_q <= cnt_q + 4'd1;
                for (int i = 0; i < LANES; i++) begin
                    base_q[i] <= base_sq[i];
                    acc_q[i]  <= acc_nx[i];
                end
            end
        end
    end

endmodule
